// File: rtl/segment_digit_recognizer.sv
// rtl/segment_digit_recognizer.sv - debounced 7-segment digit recognizer with 4-digit history and scanned display
module segment_digit_recognizer #(
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int REFRESH_DIV   = 100_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  segments,
   output logic [3:0]  digit,
   output logic        digit_valid,
   output logic        commit,
   output logic [15:0] history,
   output logic [2:0]  hist_count,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int              CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_PRE = CW'(STABLE_CYCLES - 1);
   localparam int              DW      = $clog2(REFRESH_DIV + 1);
   localparam logic [DW-1:0]   DIV_MAX = DW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLING = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t          state;
   logic [6:0]      seg_q;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   div_cnt;
   logic [1:0]      slot;
   logic [3:0]      slot_nibble;
   logic            changed;

   // Segment mask to decimal digit; anything not a clean digit shape is 4'hF.
   function automatic logic [3:0] decode(input logic [6:0] m);
      case (m)
         7'h3F:   decode = 4'd0;
         7'h06:   decode = 4'd1;
         7'h5B:   decode = 4'd2;
         7'h4F:   decode = 4'd3;
         7'h66:   decode = 4'd4;
         7'h6D:   decode = 4'd5;
         7'h7D:   decode = 4'd6;
         7'h07:   decode = 4'd7;
         7'h7F:   decode = 4'd8;
         7'h6F:   decode = 4'd9;
         default: decode = 4'hF;
      endcase
   endfunction

   // Decimal digit to active-high {g,f,e,d,c,b,a} pattern.
   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'h3F;
         4'd1:    encode = 7'h06;
         4'd2:    encode = 7'h5B;
         4'd3:    encode = 7'h4F;
         4'd4:    encode = 7'h66;
         4'd5:    encode = 7'h6D;
         4'd6:    encode = 7'h7D;
         4'd7:    encode = 7'h07;
         4'd8:    encode = 7'h7F;
         4'd9:    encode = 7'h6F;
         default: encode = 7'h00;
      endcase
   endfunction

   assign changed = (segments != seg_q);
   assign digit   = decode(seg_q);

   // Capture a new pattern and time how long it has stayed unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= 7'h00;
         cnt   <= '0;
      end else if (changed) begin
         seg_q <= segments;
         cnt   <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Recognition FSM; the commit and history update happen only on SETTLING->LOCKED.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         digit_valid <= 1'b0;
         commit      <= 1'b0;
         history     <= 16'h0000;
         hist_count  <= 3'd0;
      end else begin
         commit <= 1'b0;
         if (changed) begin
            state       <= (decode(segments) != 4'hF) ? SETTLING : IDLE;
            digit_valid <= 1'b0;
         end else begin
            case (state)
               SETTLING: begin
                  if (cnt == CNT_PRE) begin
                     state       <= LOCKED;
                     digit_valid <= 1'b1;
                     commit      <= 1'b1;
                     history     <= {history[11:0], digit};
                     if (hist_count != 3'd4) begin
                        hist_count <= hist_count + 3'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Free-running display scan, independent of the recognizer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         slot    <= 2'd0;
      end else if (div_cnt == DIV_MAX) begin
         div_cnt <= '0;
         slot    <= slot + 2'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Drive the active slot; slots beyond the committed count stay dark.
   always_comb begin
      an          = ~(4'(4'b0001 << slot));
      slot_nibble = history[{slot, 2'b00} +: 4];
      seg         = 7'h7F;
      if ({1'b0, slot} < hist_count) begin
         seg = ~encode(slot_nibble);
      end
   end

endmodule

// File: tb/tb_segment_digit_recognizer.sv
// tb/tb_segment_digit_recognizer.sv - directed self-checking bench for segment_digit_recognizer
module tb_segment_digit_recognizer;

   logic        clk;
   logic        reset;
   logic [6:0]  segments;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        commit;
   logic [15:0] history;
   logic [2:0]  hist_count;
   logic [3:0]  an;
   logic [6:0]  seg;

   int compared;
   int mismatched;
   int ncommits;
   int c0;
   int w;

   segment_digit_recognizer #(
      .STABLE_CYCLES(4),
      .REFRESH_DIV  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .segments   (segments),
      .digit      (digit),
      .digit_valid(digit_valid),
      .commit     (commit),
      .history    (history),
      .hist_count (hist_count),
      .an         (an),
      .seg        (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count commit pulses away from the active edge.
   always @(negedge clk) begin
      if (commit === 1'b1) ncommits = ncommits + 1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared = compared + 1;
      assert (obs === exp) else begin
         mismatched = mismatched + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_digit"}, 16'(digit), 16'hF);
      check({tag, "_valid"}, 16'(digit_valid), 16'h0);
      check({tag, "_commit"}, 16'(commit), 16'h0);
      check({tag, "_history"}, history, 16'h0000);
      check({tag, "_count"}, 16'(hist_count), 16'h0);
      check({tag, "_an"}, 16'(an), 16'hE);
      check({tag, "_seg"}, 16'(seg), 16'h7F);
   endtask

   task automatic commit_pattern(input string tag, input logic [6:0] p,
                                 input logic [15:0] exp_hist, input logic [2:0] exp_cnt);
      segments = 7'h00;
      step(2);
      segments = p;
      step(5);
      check({tag, "_commit"}, 16'(commit), 16'h1);
      check({tag, "_history"}, history, exp_hist);
      check({tag, "_count"}, 16'(hist_count), 16'(exp_cnt));
      step(1);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      ncommits   = 0;
      reset      = 1'b1;
      segments   = 7'h00;
      step(2);
      check_reset_outputs("por");
      reset = 1'b0;
      step(1);

      // Reset mid-settle: asynchronous clear, nothing committed.
      c0 = ncommits;
      segments = 7'h3F;
      step(3);
      check("settle_digit", 16'(digit), 16'h0);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("async");
      segments = 7'h00;
      step(2);
      reset = 1'b0;
      step(20);
      check("zero_no_commit", 16'(ncommits - c0), 16'h0);
      check("zero_digit", 16'(digit), 16'hF);

      // Single commit of 2, exactly four edges after capture.
      c0 = ncommits;
      segments = 7'h5B;
      step(1);
      check("sc_capture_digit", 16'(digit), 16'h2);
      check("sc_capture_commit", 16'(commit), 16'h0);
      step(3);
      check("sc_early_commit", 16'(commit), 16'h0);
      check("sc_early_valid", 16'(digit_valid), 16'h0);
      step(1);
      check("sc_commit", 16'(commit), 16'h1);
      check("sc_valid", 16'(digit_valid), 16'h1);
      check("sc_history", history, 16'h0002);
      check("sc_count", 16'(hist_count), 16'h1);
      step(1);
      check("sc_commit_low", 16'(commit), 16'h0);
      check("sc_valid_hold", 16'(digit_valid), 16'h1);
      step(50);
      check("sc_once", 16'(ncommits - c0), 16'h1);
      check("sc_valid_late", 16'(digit_valid), 16'h1);

      // Glitch at the last possible edge restarts the count.
      c0 = ncommits;
      segments = 7'h06;
      step(3);
      segments = 7'h07;
      step(1);
      check("gl_no_commit_a", 16'(ncommits - c0), 16'h0);
      segments = 7'h06;
      step(4);
      check("gl_no_commit_b", 16'(commit), 16'h0);
      step(1);
      check("gl_commit", 16'(commit), 16'h1);
      step(10);
      check("gl_once", 16'(ncommits - c0), 16'h1);
      check("gl_history", history, 16'h0021);
      check("gl_count", 16'(hist_count), 16'h2);

      // History fill and overflow.
      commit_pattern("ov3", 7'h4F, 16'h0213, 3'd3);
      commit_pattern("ov5", 7'h6D, 16'h2135, 3'd4);
      commit_pattern("ov8", 7'h7F, 16'h1358, 3'd4);
      commit_pattern("ov9", 7'h6F, 16'h3589, 3'd4);
      commit_pattern("ov0", 7'h3F, 16'h5890, 3'd4);
      commit_pattern("ov7a", 7'h07, 16'h8907, 3'd4);
      commit_pattern("ov7b", 7'h07, 16'h9077, 3'd4);

      // Invalid pattern never commits.
      c0 = ncommits;
      segments = 7'h01;
      step(20);
      check("inv_no_commit", 16'(ncommits - c0), 16'h0);
      check("inv_digit", 16'(digit), 16'hF);
      check("inv_valid", 16'(digit_valid), 16'h0);
      check("inv_history", history, 16'h9077);

      // Display scan with a single committed 4.
      reset = 1'b1;
      segments = 7'h00;
      step(1);
      reset = 1'b0;
      step(1);
      commit_pattern("ds4", 7'h66, 16'h0004, 3'd1);
      w = 0;
      while (an === 4'b1110 && w < 20) begin
         step(1);
         w = w + 1;
      end
      while (an !== 4'b1110 && w < 40) begin
         step(1);
         w = w + 1;
      end
      check("scan_align", 16'(w < 40), 16'h1);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 2; j++) begin
            check($sformatf("scan_an%0d_%0d", k, j), 16'(an), 16'(~(4'b0001 << k) & 4'hF));
            check($sformatf("scan_seg%0d_%0d", k, j), 16'(seg), (k == 0) ? 16'h0019 : 16'h007F);
            step(1);
         end
      end
      check("scan_wrap", 16'(an), 16'hE);

      // Asynchronous reset with history present.
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("async2");
      step(1);
      reset = 1'b0;
      step(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/segment_digit_recognizer.md
# segment_digit_recognizer

Downstream consumer of the OLED drawing stage's 7-bit `mouse_click` segment mask (bit0=a top, 1=b upper-right, 2=c lower-right, 3=d bottom, 4=e lower-left, 5=f upper-left, 6=g middle). It waits for a drawn pattern to stay unchanged for a programmable hold time, decodes it to a decimal digit, and commits each new digit once into a 4-digit history. The history is shown on the board's multiplexed 4-digit 7-segment display.

## Interface
- `STABLE_CYCLES`, 1_000_000: consecutive unchanged cycles required before commit; legal range ≥2.
- `REFRESH_DIV`, 100_000: clk cycles per display digit slot; legal range ≥1.
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `segments` in 7: segment mask from the drawing stage; bit order as above.
- `digit` out 4: decode of the registered pattern; 4'hF when the pattern is invalid.
- `digit_valid` out 1: high while the FSM is in LOCKED.
- `commit` out 1: one-cycle pulse when a digit enters the history.
- `history` out 16: last four committed digits; [3:0] is the newest.
- `hist_count` out 3: number of committed digits, saturating at 4.
- `an` out 4: display anodes, active-low.
- `seg` out 7: display cathodes, active-low, in {g,f,e,d,c,b,a} order.

## Operation
- **Input register.** `seg_q` (7b) captures `segments` whenever they differ. On a capture, `cnt` is cleared to 0.
- **Stability counter.** When `segments == seg_q`, `cnt` increments and saturates at `STABLE_CYCLES`. Counter width is clog2(`STABLE_CYCLES`+1).
- **Decode of `seg_q`.** Any other value, including 0x00, is invalid.
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4
  - 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9
- **FSM states.**
  - IDLE: `seg_q` is invalid.
  - SETTLING: `seg_q` is valid and `cnt` < `STABLE_CYCLES`.
  - LOCKED: `seg_q` is valid and `cnt` == `STABLE_CYCLES`.
- **FSM transitions.**
  - Any input change leaves LOCKED or SETTLING and goes to SETTLING (new pattern valid) or IDLE (new pattern invalid).
  - IDLE stays in IDLE until a valid pattern is captured.
- **Commit.** A commit occurs on the SETTLING→LOCKED transition only. It is registered: `commit` rises on the edge where `cnt` goes `STABLE_CYCLES`-1 → `STABLE_CYCLES`.
  - Same edge: `history <= {history[11:0], digit}` and `hist_count` increments, saturating at 4.
  - A pattern held indefinitely commits exactly once.
  - Redrawing the same digit commits again only after a different pattern has been present for at least one cycle.
- **Display.**
  - A scan counter advances the slot index 0→1→2→3→0 every `REFRESH_DIV` cycles.
  - Slot k drives `an[k]` low and shows `history[4k+3:4k]` as the inverted standard 7-segment pattern.
  - Slots with k ≥ `hist_count` are blanked: `seg` = 7'h7F.

## Timing
- **Reset values.**
  - Outputs: `digit`=4'hF, `digit_valid`=0, `commit`=0, `history`=16'h0000, `hist_count`=0, `an`=4'b1110, `seg`=7'h7F.
  - Internal: `seg_q`=0, `cnt`=0, scan index 0, FSM in IDLE.
- **Commit latency.**
  - Input stable from edge E0, where `seg_q` is loaded.
  - `commit` and `digit_valid` go high after edge E0+`STABLE_CYCLES`.
  - `commit` is low again after the next edge; `digit_valid` stays high.
- **Glitch rejection.** An input change at edge E0+`STABLE_CYCLES`-1 or earlier restarts the count, and nothing is committed.
- **Decode latency.** `digit` tracks `seg_q` combinationally: 1 cycle after the input changes.
- **Reset mid-settle.** No commit occurs. After reset, the pattern must be re-captured and re-timed from zero.
- **History overflow.** On the fifth and later commits, the oldest digit ([15:12]) is discarded and `hist_count` stays 4.
- **Display independence.** The scan index wraps 3→0 and runs regardless of the FSM. A history update is visible in its slot on the next clock.

## Test plan
Run with `STABLE_CYCLES`=4 and `REFRESH_DIV`=2.
1. **Reset.** Assert reset mid-run → all outputs at reset values immediately, without waiting for a clock. Release, hold `segments`=0x00 for 20 cycles → `commit` never asserts, `digit`=4'hF.
2. **Single commit.** Apply 0x5B and hold → `commit` high for exactly 1 cycle, 4 edges after capture. Then `history`=16'h0002, `hist_count`=1, `digit_valid` stays 1, with no second pulse over 50 cycles.
3. **Glitch rejection.** Hold 0x06 for 3 cycles, then 0x07, then back to 0x06 and hold → only one commit of 1.
4. **History overflow.** Commit 3,5,8,9,0 (separated by 0x00 gaps) → `history`=16'h5890, `hist_count`=4. Commit 7 twice (with a 0x00 gap) → `history`=16'h8907 then 16'h9077.
5. **Invalid pattern.** Hold 0x01 for 20 cycles → `digit`=4'hF, no commit, `digit_valid`=0.
6. **Display scan.** After committing 4 (`hist_count`=1) → `an` cycles 1110,1101,1011,0111 every 2 cycles.
   - `seg`=7'b0011001 while `an`=1110.
   - `seg`=7'h7F in the other three slots.
